ex_stage: RTL

- Execute stage that consumes the ID/EX pipeline register outputs (control bundle, PC+4, RD1, RD2, sign-extended immediate, rt/rd fields).
- Single-cycle ALU ops: result registered into the EX/MEM outputs one cycle later.
- MUL: iterative shift-add over WIDTH steps, holding the upstream pipeline via stall.
- Produces the branch target, zero flag and destination register for the MEM stage.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/mul_iter.sv | 54 +++++
 rtl/ex_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM states and the
// WB/M control bundle carried through EX/MEM.
package ex_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_MUL   = 3'b101;
    localparam logic [2:0] ALU_NOR   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } stateT;

    typedef struct packed {
        logic memReg;
        logic regWrite;
        logic branch;
        logic memWrite;
        logic memRead;
    } ctrlT;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// done is asserted during the last step; product is valid in that cycle.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;
    logic [CW-1:0]    cnt;

    // product is taken from the in-flight step so the result leaves with the last edge
    assign accNext = acc + (mplier[0] ? mcand : '0);
    assign product = accNext;
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= opA;
            mplier <= opB;
        end else if (busy) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU into EX/MEM, plus an iterative MUL that
// holds the upstream pipeline through stall until its last step.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_mem_reg,
    input  logic             in_reg_write,
    input  logic             in_branch,
    input  logic             in_mem_write,
    input  logic             in_mem_read,
    input  logic             in_reg_dst,
    input  logic [2:0]       in_alu_op,
    input  logic             in_alu_src,
    input  logic [WIDTH-1:0] in_add,
    input  logic [WIDTH-1:0] in_rd1,
    input  logic [WIDTH-1:0] in_rd2,
    input  logic [WIDTH-1:0] in_sinex,
    input  logic [RADDR-1:0] in_rt,
    input  logic [RADDR-1:0] in_rd,
    output logic             stall,
    output logic             out_valid,
    output logic             out_mem_reg,
    output logic             out_reg_write,
    output logic             out_branch,
    output logic             out_mem_write,
    output logic             out_mem_read,
    output logic [WIDTH-1:0] out_branch_target,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_alu_result,
    output logic [WIDTH-1:0] out_write_data,
    output logic [RADDR-1:0] out_write_reg
);

    stateT            state;
    stateT            stateNext;
    ctrlT             inCtrl;
    ctrlT             mulCtrl;
    ctrlT             outCtrl;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] mulTarget;
    logic [WIDTH-1:0] mulWData;
    logic [WIDTH-1:0] product;
    logic [RADDR-1:0] writeReg;
    logic [RADDR-1:0] mulWReg;
    logic             mulStart;
    logic             mulBusy;
    logic             mulDone;

    assign inCtrl = '{memReg:   in_mem_reg,
                      regWrite: in_reg_write,
                      branch:   in_branch,
                      memWrite: in_mem_write,
                      memRead:  in_mem_read};

    assign opB          = in_alu_src ? in_sinex : in_rd2;
    assign writeReg     = in_reg_dst ? in_rd : in_rt;
    assign branchTarget = in_add + (in_sinex << 2);

    always_comb begin
        aluResult = '0;
        case (in_alu_op)
            ALU_ADD:   aluResult = in_rd1 + opB;
            ALU_SUB:   aluResult = in_rd1 - opB;
            ALU_AND:   aluResult = in_rd1 & opB;
            ALU_OR:    aluResult = in_rd1 | opB;
            ALU_SLT:   aluResult = {{(WIDTH-1){1'b0}}, ($signed(in_rd1) < $signed(opB))};
            ALU_NOR:   aluResult = ~(in_rd1 | opB);
            ALU_PASSB: aluResult = opB;
            default:   aluResult = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        mulStart  = 1'b0;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && (in_alu_op == ALU_MUL)) begin
                    mulStart  = 1'b1;
                    stall     = 1'b1;
                    stateNext = ST_MUL;
                end
            end
            ST_MUL: begin
                // the last step releases upstream so it advances on the exit edge
                stall = mulBusy && !mulDone;
                if (mulDone) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        if (flush) begin
            stateNext = ST_IDLE;
            mulStart  = 1'b0;
            stall     = 1'b0;
        end
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) uMul (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (mulStart),
        .opA    (in_rd1),
        .opB    (opB),
        .busy   (mulBusy),
        .done   (mulDone),
        .product(product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mulCtrl   <= '0;
            mulTarget <= '0;
            mulWData  <= '0;
            mulWReg   <= '0;
        end else if (mulStart) begin
            mulCtrl   <= inCtrl;
            mulTarget <= branchTarget;
            mulWData  <= in_rd2;
            mulWReg   <= writeReg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid         <= 1'b0;
            outCtrl           <= '0;
            out_branch_target <= '0;
            out_zero          <= 1'b0;
            out_alu_result    <= '0;
            out_write_data    <= '0;
            out_write_reg     <= '0;
        end else if (flush || mulStart || ((state == ST_MUL) && !mulDone)) begin
            out_valid <= 1'b0;
            outCtrl   <= '0;
        end else if (state == ST_MUL) begin
            out_valid         <= 1'b1;
            outCtrl           <= mulCtrl;
            out_branch_target <= mulTarget;
            out_zero          <= (product == '0);
            out_alu_result    <= product;
            out_write_data    <= mulWData;
            out_write_reg     <= mulWReg;
        end else begin
            out_valid         <= in_valid;
            outCtrl           <= in_valid ? inCtrl : '0;
            out_branch_target <= branchTarget;
            out_zero          <= (aluResult == '0);
            out_alu_result    <= aluResult;
            out_write_data    <= in_rd2;
            out_write_reg     <= writeReg;
        end
    end

    assign out_mem_reg   = outCtrl.memReg;
    assign out_reg_write = outCtrl.regWrite;
    assign out_branch    = outCtrl.branch;
    assign out_mem_write = outCtrl.memWrite;
    assign out_mem_read  = outCtrl.memRead;

endmodule
